// File: rtl/sseg_scan_decoder.sv
// rtl/sseg_scan_decoder.sv - multiplexed seven-segment scan sniffer that rebuilds a 16-bit display value
module sseg_scan_decoder #(
    parameter int STABLE_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  sseg_in,
    input  logic [3:0]  an_in,
    output logic [15:0] value,
    output logic        valid,
    output logic [3:0]  digit_err,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } state_t;

    // Counter value that, once incremented, equals STABLE_CYCLES
    localparam logic [3:0] LAST_CNT = 4'(STABLE_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [6:0]  ref_seg;
    logic [3:0]  ref_an;
    logic [3:0]  mask;
    logic [15:0] pend_val;
    logic [3:0]  pend_err;

    logic        an_onehot;
    logic        same_in;
    logic [1:0]  idx;
    logic [3:0]  dec_nib;
    logic        dec_bad;
    logic        capture;
    logic        publish;
    logic [3:0]  mask_next;

    // Input classification, digit index and segment decode
    always_comb begin
        an_onehot = (an_in != 4'b0000) && ((an_in & (an_in - 4'd1)) == 4'b0000);
        same_in   = (sseg_in == ref_seg) && (an_in == ref_an);
        idx       = 2'd0;
        case (an_in)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        dec_bad = 1'b0;
        case (sseg_in)
            7'b0111111: dec_nib = 4'h0;
            7'b0000110: dec_nib = 4'h1;
            7'b1011011: dec_nib = 4'h2;
            7'b1001111: dec_nib = 4'h3;
            7'b1100110: dec_nib = 4'h4;
            7'b1101101: dec_nib = 4'h5;
            7'b1111101: dec_nib = 4'h6;
            7'b0000111: dec_nib = 4'h7;
            7'b1111111: dec_nib = 4'h8;
            7'b1100111: dec_nib = 4'h9;
            7'b1110111: dec_nib = 4'hA;
            7'b1111100: dec_nib = 4'hB;
            7'b0111001: dec_nib = 4'hC;
            7'b1011110: dec_nib = 4'hD;
            7'b1111001: dec_nib = 4'hE;
            7'b1110001: dec_nib = 4'hF;
            default: begin
                dec_nib = 4'h0;
                dec_bad = 1'b1;
            end
        endcase
    end

    // Capture fires on the edge the counter would reach STABLE_CYCLES; a full
    // mask publishes one edge later and a same-edge capture starts the new mask
    always_comb begin
        capture   = (state == SETTLE) && an_onehot && same_in && (cnt == LAST_CNT);
        publish   = (mask == 4'b1111);
        mask_next = publish ? 4'b0000 : mask;
        if (capture) begin
            mask_next[idx] = 1'b1;
        end
    end

    // Scan FSM, pending slots and published outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            ref_seg    <= 7'd0;
            ref_an     <= 4'd0;
            mask       <= 4'b0000;
            pend_val   <= 16'h0000;
            pend_err   <= 4'b0000;
            value      <= 16'h0000;
            digit_err  <= 4'b0000;
            valid      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            mask       <= mask_next;

            if (publish) begin
                value      <= pend_val;
                digit_err  <= pend_err;
                valid      <= 1'b1;
                frame_done <= 1'b1;
            end

            if (capture) begin
                pend_val[idx*4 +: 4] <= dec_nib;
                pend_err[idx]        <= dec_bad;
            end

            case (state)
                IDLE: begin
                    cnt <= 4'd0;
                    if (an_onehot) begin
                        state   <= SETTLE;
                        cnt     <= 4'd1;
                        ref_seg <= sseg_in;
                        ref_an  <= an_in;
                    end
                end
                SETTLE, HELD: begin
                    if (!an_onehot) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else if (!same_in) begin
                        state   <= SETTLE;
                        cnt     <= 4'd1;
                        ref_seg <= sseg_in;
                        ref_an  <= an_in;
                    end else if (state == SETTLE) begin
                        cnt <= cnt + 4'd1;
                        if (capture) begin
                            state <= HELD;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// tb/tb_sseg_scan_decoder.sv - self-checking bench for sseg_scan_decoder
module tb_sseg_scan_decoder;

    localparam int S = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  sseg_in;
    logic [3:0]  an_in;
    logic [15:0] value;
    logic        valid;
    logic [3:0]  digit_err;
    logic        frame_done;

    sseg_scan_decoder #(.STABLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sseg_in    (sseg_in),
        .an_in      (an_in),
        .value      (value),
        .valid      (valid),
        .digit_err  (digit_err),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int failures  = 0;
    int fd_seen   = 0;

    logic [6:0] seg_tab [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1100111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    // Reference model: run-length of identical one-hot input words
    int          run_len;
    logic [10:0] prev_in;
    logic [3:0]  m_pend_val [4];
    logic        m_pend_err [4];
    logic [3:0]  m_mask;
    logic [15:0] m_value;
    logic [3:0]  m_err;
    logic        m_valid;
    logic        m_fd;

    function automatic int decode(input logic [6:0] s);
        for (int k = 0; k < 16; k++) begin
            if (seg_tab[k] == s) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        run_len = 0;
        prev_in = '0;
        m_mask  = 4'b0000;
        m_value = 16'h0000;
        m_err   = 4'b0000;
        m_valid = 1'b0;
        m_fd    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_pend_val[i] = 4'h0;
            m_pend_err[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic [10:0] cur;
        int d;
        int k;
        cur  = {sseg_in, an_in};
        m_fd = 1'b0;
        if (m_mask == 4'b1111) begin
            for (int i = 0; i < 4; i++) begin
                m_value[i*4 +: 4] = m_pend_val[i];
                m_err[i]          = m_pend_err[i];
            end
            m_valid = 1'b1;
            m_fd    = 1'b1;
            m_mask  = 4'b0000;
        end
        if ($countones(an_in) == 1) begin
            if (run_len > 0 && cur == prev_in) run_len++;
            else run_len = 1;
            prev_in = cur;
            if (run_len == S) begin
                d = 0;
                for (int i = 0; i < 4; i++) if (an_in[i]) d = i;
                k = decode(sseg_in);
                m_pend_val[d] = (k < 0) ? 4'h0 : 4'(k);
                m_pend_err[d] = (k < 0);
                m_mask[d]     = 1'b1;
            end
        end else begin
            run_len = 0;
        end
    endtask

    task automatic step(input logic [6:0] s, input logic [3:0] a);
        sseg_in = s;
        an_in   = a;
        @(posedge clk);
        model_edge();
        #1;
        if (frame_done === 1'b1) fd_seen++;
    endtask

    task automatic hold(input int d, input int nib, input int n);
        for (int i = 0; i < n; i++) step(seg_tab[nib], 4'(1 << d));
    endtask

    task automatic hold_seg(input int d, input logic [6:0] s, input int n);
        for (int i = 0; i < n; i++) step(s, 4'(1 << d));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        an_in = 4'b0000;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        sseg_in = 7'd0;
        an_in   = 4'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        tests_run++; if (value !== 16'h0000) begin failures++; $display("FAIL reset_value got=%h want=0000", value); end
        tests_run++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", valid); end
        tests_run++; if (digit_err !== 4'b0000) begin failures++; $display("FAIL reset_err got=%b want=0000", digit_err); end
        tests_run++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_fd got=%b want=0", frame_done); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_scan();
        hold(0, 15, 5);
        hold(1, 3, 5);
        hold(2, 10, 5);
        hold(3, 1, 3);
        tests_run++; if (frame_done !== 1'b0 || valid !== 1'b0) begin failures++; $display("FAIL basic_capture_edge got fd=%b valid=%b want fd=0 valid=0", frame_done, valid); end
        hold(3, 1, 1);
        tests_run++; if (frame_done !== 1'b1) begin failures++; $display("FAIL basic_fd got=%b want=1", frame_done); end
        tests_run++; if (value !== 16'h1A3F) begin failures++; $display("FAIL basic_value got=%h want=1a3f", value); end
        tests_run++; if (digit_err !== 4'b0000 || valid !== 1'b1) begin failures++; $display("FAIL basic_err_valid got err=%b valid=%b want 0000/1", digit_err, valid); end
        hold(3, 1, 1);
        tests_run++; if (frame_done !== 1'b0 || value !== 16'h1A3F) begin failures++; $display("FAIL basic_after got fd=%b value=%h want 0/1a3f", frame_done, value); end
    endtask

    task automatic test_glitch();
        int f0;
        do_reset();
        f0 = fd_seen;
        hold(0, 0, 4);
        hold(2, 5, 4);
        hold(3, 6, 4);
        hold_seg(1, 7'b1111111, 2);
        hold(1, 3, 3);
        tests_run++; if (fd_seen != f0) begin failures++; $display("FAIL glitch_early_frame got=%0d want=0", fd_seen - f0); end
        hold(1, 3, 1);
        tests_run++; if (frame_done !== 1'b1 || value !== 16'h6530) begin failures++; $display("FAIL glitch_value got fd=%b value=%h want 1/6530", frame_done, value); end
    endtask

    task automatic test_invalid();
        hold(0, 1, 4);
        hold(1, 2, 4);
        hold_seg(2, 7'b0000000, 4);
        hold(3, 4, 4);
        tests_run++; if (value !== 16'h4021 || digit_err !== 4'b0100) begin failures++; $display("FAIL invalid_digit got value=%h err=%b want 4021/0100", value, digit_err); end
        hold(0, 1, 4);
        hold(1, 2, 4);
        hold(2, 9, 4);
        hold(3, 4, 4);
        tests_run++; if (value !== 16'h4921 || digit_err !== 4'b0000) begin failures++; $display("FAIL invalid_recover got value=%h err=%b want 4921/0000", value, digit_err); end
    endtask

    task automatic test_idle_gap();
        int f0;
        f0 = fd_seen;
        hold(0, 7, 4);
        for (int i = 0; i < 10; i++) step(7'b1111001, 4'b0011);
        hold(1, 8, 4);
        for (int i = 0; i < 10; i++) step(7'b1111001, 4'b0000);
        hold(2, 9, 4);
        tests_run++; if (fd_seen != f0) begin failures++; $display("FAIL idle_gap_early got=%0d frames want=0", fd_seen - f0); end
        hold(3, 2, 4);
        tests_run++; if (fd_seen != f0 + 1 || value !== 16'h2987) begin failures++; $display("FAIL idle_gap_frame got frames=%0d value=%h want 1/2987", fd_seen - f0, value); end
    endtask

    task automatic test_reset_mid();
        int f0;
        hold(1, 7, 4);
        hold(2, 8, 4);
        hold(3, 9, 4);
        rst_n = 1'b0;
        model_reset();
        #1;
        tests_run++; if (value !== 16'h0000 || valid !== 1'b0) begin failures++; $display("FAIL reset_mid_async got value=%h valid=%b want 0000/0", value, valid); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        f0 = fd_seen;
        hold(0, 5, 4);
        hold(1, 12, 4);
        hold(2, 0, 4);
        tests_run++; if (fd_seen != f0) begin failures++; $display("FAIL reset_mid_stale got=%0d frames want=0", fd_seen - f0); end
        hold(3, 0, 6);
        tests_run++; if (fd_seen != f0 + 1 || value !== 16'h00C5 || valid !== 1'b1) begin failures++; $display("FAIL reset_mid_frame got frames=%0d value=%h valid=%b want 1/00c5/1", fd_seen - f0, value, valid); end
    endtask

    task automatic test_publish_edge();
        int f0;
        do_reset();
        hold(1, 1, 4);
        hold(2, 2, 4);
        hold(3, 3, 4);
        hold(0, 4, 3);
        hold(1, 9, 1);
        tests_run++; if (frame_done !== 1'b1 || value !== 16'h3214) begin failures++; $display("FAIL pub_edge_frame got fd=%b value=%h want 1/3214", frame_done, value); end
        hold(1, 9, 3);
        f0 = fd_seen;
        hold(0, 5, 4);
        hold(2, 6, 4);
        tests_run++; if (fd_seen != f0) begin failures++; $display("FAIL pub_edge_early got=%0d frames want=0", fd_seen - f0); end
        hold(3, 7, 4);
        tests_run++; if (fd_seen != f0 + 1 || value !== 16'h7695) begin failures++; $display("FAIL pub_edge_next got frames=%0d value=%h want 1/7695", fd_seen - f0, value); end
    endtask

    task automatic test_random();
        logic [3:0] a;
        logic [6:0] s;
        int dwell;
        do_reset();
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 9) == 0) begin
                a = 4'($urandom_range(0, 15));
                while ($countones(a) == 1) a = 4'($urandom_range(0, 15));
            end else begin
                a = 4'(1 << $urandom_range(0, 3));
            end
            if ($urandom_range(0, 4) == 0) s = 7'($urandom_range(0, 127));
            else s = seg_tab[$urandom_range(0, 15)];
            dwell = $urandom_range(1, 6);
            for (int i = 0; i < dwell; i++) begin
                step(s, a);
                tests_run++;
                if (value !== m_value || digit_err !== m_err || valid !== m_valid || frame_done !== m_fd) begin
                    failures++;
                    $display("FAIL random t=%0d got value=%h err=%b valid=%b fd=%b want %h/%b/%b/%b",
                             t, value, digit_err, valid, frame_done, m_value, m_err, m_valid, m_fd);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_glitch();
        test_invalid();
        test_idle_gap();
        test_reset_mid();
        test_publish_edge();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
